// File: rtl/rv_mc_pkg.sv
// Shared definitions for the multicycle RV32I controller: state encoding, major opcodes
// and the datapath select encodings driven by the controller.
package rv_mc_pkg;

   typedef enum logic [3:0] {
      StFetch,
      StDecode,
      StMemAdr,
      StMemRead,
      StMemWb,
      StMemWrite,
      StExecR,
      StExecI,
      StExecU,
      StAluWb,
      StBranch,
      StJal,
      StJalr,
      StJlink
   } state_e;

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpReg    = 7'b0110011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpFence  = 7'b0001111;

   localparam logic [3:0] AluAdd  = 4'd0;
   localparam logic [3:0] AluSub  = 4'd1;
   localparam logic [3:0] AluAnd  = 4'd2;
   localparam logic [3:0] AluOr   = 4'd3;
   localparam logic [3:0] AluXor  = 4'd4;
   localparam logic [3:0] AluSlt  = 4'd5;
   localparam logic [3:0] AluSltu = 4'd6;
   localparam logic [3:0] AluSll  = 4'd7;
   localparam logic [3:0] AluSrl  = 4'd8;
   localparam logic [3:0] AluSra  = 4'd9;

   localparam logic [2:0] ImmI = 3'b000;
   localparam logic [2:0] ImmS = 3'b001;
   localparam logic [2:0] ImmB = 3'b010;
   localparam logic [2:0] ImmJ = 3'b011;
   localparam logic [2:0] ImmU = 3'b100;

   localparam logic [1:0] ResAluOut    = 2'b00;
   localparam logic [1:0] ResData      = 2'b01;
   localparam logic [1:0] ResAluResult = 2'b10;

   localparam logic [1:0] SrcAPc    = 2'b00;
   localparam logic [1:0] SrcAOldPc = 2'b01;
   localparam logic [1:0] SrcAReg   = 2'b10;
   localparam logic [1:0] SrcAZero  = 2'b11;

   localparam logic [1:0] SrcBReg  = 2'b00;
   localparam logic [1:0] SrcBImm  = 2'b01;
   localparam logic [1:0] SrcBFour = 2'b10;

   // FENCE counts as supported only when it is configured to retire as a no-op.
   function automatic logic op_supported(input logic [6:0] op, input logic fence_nop);
      case (op)
         OpLoad, OpStore, OpReg, OpImm, OpBranch,
         OpJal, OpJalr, OpLui, OpAuipc: op_supported = 1'b1;
         OpFence:                       op_supported = fence_nop;
         default:                       op_supported = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7[5] to an ALU operation; immediate forms never select SUB and only
// use funct7[5] to pick arithmetic versus logical right shift.
module alu_decoder
   import rv_mc_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       reg_op,
   output logic [3:0] alu_control
);

   always_comb begin
      alu_control = AluAdd;
      case (funct3)
         3'b000: alu_control = (reg_op && funct7b5) ? AluSub : AluAdd;
         3'b001: alu_control = AluSll;
         3'b010: alu_control = AluSlt;
         3'b011: alu_control = AluSltu;
         3'b100: alu_control = AluXor;
         3'b101: alu_control = funct7b5 ? AluSra : AluSrl;
         3'b110: alu_control = AluOr;
         3'b111: alu_control = AluAnd;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Moore-style control FSM for a multicycle RV32I datapath; write strobes are additionally
// qualified by MemReady (fetch), Taken (branch) and reset.
module mc_controller
   import rv_mc_pkg::*;
#(
   parameter bit FENCE_NOP = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] Op,
   input  logic [2:0] Funct3,
   input  logic       Funct7b5,
   input  logic       Taken,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       PCLsbClr,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ImmSrc,
   output logic [3:0] ALUControl,
   output logic       Illegal
);

   state_e     state_q, state_d;
   logic [3:0] dec_alu_control;
   logic       reg_op;

   assign reg_op = (state_q == StExecR);

   alu_decoder u_alu_decoder (
      .funct3      (Funct3),
      .funct7b5    (Funct7b5),
      .reg_op      (reg_op),
      .alu_control (dec_alu_control)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      PCWrite    = 1'b0;
      PCLsbClr   = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = ResAluOut;
      ALUSrcA    = SrcAPc;
      ALUSrcB    = SrcBReg;
      ImmSrc     = ImmI;
      ALUControl = AluAdd;
      Illegal    = 1'b0;

      unique case (state_q)
         StFetch: begin
            ALUSrcB   = SrcBFour;
            ResultSrc = ResAluResult;
            IRWrite   = MemReady;
            PCWrite   = MemReady;
            if (MemReady) state_d = StDecode;
         end
         StDecode: begin
            // Speculatively form the branch/jump target into ALUOut.
            ALUSrcA = SrcAOldPc;
            ALUSrcB = SrcBImm;
            ImmSrc  = (Op == OpJal) ? ImmJ : ImmB;
            state_d = StFetch;
            if (!op_supported(Op, FENCE_NOP)) begin
               Illegal = 1'b1;
            end else begin
               case (Op)
                  OpLoad, OpStore: state_d = StMemAdr;
                  OpReg:           state_d = StExecR;
                  OpImm:           state_d = StExecI;
                  OpBranch:        state_d = StBranch;
                  OpJal:           state_d = StJal;
                  OpJalr:          state_d = StJalr;
                  OpLui, OpAuipc:  state_d = StExecU;
                  default:         state_d = StFetch;
               endcase
            end
         end
         StMemAdr: begin
            ALUSrcA = SrcAReg;
            ALUSrcB = SrcBImm;
            ImmSrc  = (Op == OpStore) ? ImmS : ImmI;
            state_d = (Op == OpStore) ? StMemWrite : StMemRead;
         end
         StMemRead: begin
            AdrSrc = 1'b1;
            if (MemReady) state_d = StMemWb;
         end
         StMemWb: begin
            ResultSrc = ResData;
            RegWrite  = 1'b1;
            state_d   = StFetch;
         end
         StMemWrite: begin
            // Strobe stays up across stalls so the memory sees a stable request.
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            if (MemReady) state_d = StFetch;
         end
         StExecR: begin
            ALUSrcA    = SrcAReg;
            ALUSrcB    = SrcBReg;
            ALUControl = dec_alu_control;
            state_d    = StAluWb;
         end
         StExecI: begin
            ALUSrcA    = SrcAReg;
            ALUSrcB    = SrcBImm;
            ImmSrc     = ImmI;
            ALUControl = dec_alu_control;
            state_d    = StAluWb;
         end
         StExecU: begin
            ALUSrcA = (Op == OpLui) ? SrcAZero : SrcAOldPc;
            ALUSrcB = SrcBImm;
            ImmSrc  = ImmU;
            state_d = StAluWb;
         end
         StAluWb: begin
            ResultSrc = ResAluOut;
            RegWrite  = 1'b1;
            state_d   = StFetch;
         end
         StBranch: begin
            ALUSrcA   = SrcAReg;
            ALUSrcB   = SrcBReg;
            ResultSrc = ResAluOut;
            PCWrite   = Taken;
            state_d   = StFetch;
         end
         StJal: begin
            ALUSrcA   = SrcAOldPc;
            ALUSrcB   = SrcBFour;
            ResultSrc = ResAluOut;
            PCWrite   = 1'b1;
            state_d   = StAluWb;
         end
         StJalr: begin
            ALUSrcA   = SrcAReg;
            ALUSrcB   = SrcBImm;
            ImmSrc    = ImmI;
            ResultSrc = ResAluResult;
            PCWrite   = 1'b1;
            PCLsbClr  = 1'b1;
            state_d   = StJlink;
         end
         StJlink: begin
            ALUSrcA = SrcAOldPc;
            ALUSrcB = SrcBFour;
            state_d = StAluWb;
         end
         default: state_d = StFetch;
      endcase

      if (reset) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
         Illegal  = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller: each instruction is expanded into its expected
// per-cycle output schedule and compared cycle by cycle against the DUT.
module tb_mc_controller;
   import rv_mc_pkg::*;

   localparam bit FenceNop = 1'b1;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] Op;
   logic [2:0] Funct3;
   logic       Funct7b5, Taken, MemReady;
   logic       PCWrite, PCLsbClr, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
   logic [2:0] ImmSrc;
   logic [3:0] ALUControl;

   mc_controller #(.FENCE_NOP(FenceNop)) dut (
      .clk        (clk),
      .reset      (reset),
      .Op         (Op),
      .Funct3     (Funct3),
      .Funct7b5   (Funct7b5),
      .Taken      (Taken),
      .MemReady   (MemReady),
      .PCWrite    (PCWrite),
      .PCLsbClr   (PCLsbClr),
      .AdrSrc     (AdrSrc),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegWrite   (RegWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ImmSrc     (ImmSrc),
      .ALUControl (ALUControl),
      .Illegal    (Illegal)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pcw, lsb, adr, mw, irw, rw;
      logic [1:0] res, sa, sb;
      logic [2:0] imm;
      logic [3:0] alu;
      logic       ill;
   } outs_t;

   // hold: step repeats while MemReady=0; gate_ready/gate_taken qualify PCWrite/IRWrite.
   typedef struct {
      outs_t o;
      bit    hold;
      bit    gate_ready;
      bit    gate_taken;
   } step_t;

   step_t sched[$];
   int    n_checks = 0;
   int    n_pass = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic f7, input bit r);
      case (f3)
         3'd0:    return (r && f7) ? AluSub : AluAdd;
         3'd1:    return AluSll;
         3'd2:    return AluSlt;
         3'd3:    return AluSltu;
         3'd4:    return AluXor;
         3'd5:    return f7 ? AluSra : AluSrl;
         3'd6:    return AluOr;
         default: return AluAnd;
      endcase
   endfunction

   task automatic add_step(input outs_t o, input bit hold, input bit gr, input bit gt);
      step_t s;
      s.o = o; s.hold = hold; s.gate_ready = gr; s.gate_taken = gt;
      sched.push_back(s);
   endtask

   // Writeback step shared by all register-writing ALU-path instructions.
   task automatic add_aluwb();
      outs_t o;
      o = '0; o.rw = 1'b1;
      add_step(o, 0, 0, 0);
   endtask

   task automatic build_sched(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      outs_t o;
      sched.delete();
      o = '0; o.sb = 2'b10; o.res = 2'b10; o.pcw = 1'b1; o.irw = 1'b1;
      add_step(o, 1, 1, 0);
      o = '0; o.sa = 2'b01; o.sb = 2'b01; o.imm = (op == 7'b1101111) ? 3'b011 : 3'b010;
      case (op)
         7'b0000011: begin
            add_step(o, 0, 0, 0);
            o = '0; o.sa = 2'b10; o.sb = 2'b01; o.imm = 3'b000; add_step(o, 0, 0, 0);
            o = '0; o.adr = 1'b1;                                add_step(o, 1, 0, 0);
            o = '0; o.res = 2'b01; o.rw = 1'b1;                  add_step(o, 0, 0, 0);
         end
         7'b0100011: begin
            add_step(o, 0, 0, 0);
            o = '0; o.sa = 2'b10; o.sb = 2'b01; o.imm = 3'b001; add_step(o, 0, 0, 0);
            o = '0; o.adr = 1'b1; o.mw = 1'b1;                   add_step(o, 1, 0, 0);
         end
         7'b0110011: begin
            add_step(o, 0, 0, 0);
            o = '0; o.sa = 2'b10; o.sb = 2'b00; o.alu = alu_ref(f3, f7, 1'b1);
            add_step(o, 0, 0, 0);
            add_aluwb();
         end
         7'b0010011: begin
            add_step(o, 0, 0, 0);
            o = '0; o.sa = 2'b10; o.sb = 2'b01; o.imm = 3'b000; o.alu = alu_ref(f3, f7, 1'b0);
            add_step(o, 0, 0, 0);
            add_aluwb();
         end
         7'b0110111, 7'b0010111: begin
            add_step(o, 0, 0, 0);
            o = '0; o.sa = (op == 7'b0110111) ? 2'b11 : 2'b01; o.sb = 2'b01; o.imm = 3'b100;
            add_step(o, 0, 0, 0);
            add_aluwb();
         end
         7'b1100011: begin
            add_step(o, 0, 0, 0);
            o = '0; o.sa = 2'b10; o.sb = 2'b00; o.pcw = 1'b1; add_step(o, 0, 0, 1);
         end
         7'b1101111: begin
            add_step(o, 0, 0, 0);
            o = '0; o.sa = 2'b01; o.sb = 2'b10; o.pcw = 1'b1; add_step(o, 0, 0, 0);
            add_aluwb();
         end
         7'b1100111: begin
            add_step(o, 0, 0, 0);
            o = '0; o.sa = 2'b10; o.sb = 2'b01; o.res = 2'b10; o.pcw = 1'b1; o.lsb = 1'b1;
            add_step(o, 0, 0, 0);
            o = '0; o.sa = 2'b01; o.sb = 2'b10; add_step(o, 0, 0, 0);
            add_aluwb();
         end
         7'b0001111: begin
            o.ill = !FenceNop;
            add_step(o, 0, 0, 0);
         end
         default: begin
            o.ill = 1'b1;
            add_step(o, 0, 0, 0);
         end
      endcase
   endtask

   // stall_pct >= 0: random MemReady; otherwise stall_n cycles of MemReady=0 at stall_step.
   // taken_sel < 0 randomizes Taken; rst_at is the instruction cycle that asserts reset.
   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input int stall_pct, input int stall_step, input int stall_n,
                            input int taken_sel, input int rst_at, input int exp_len,
                            input string name);
      int    idx, cyc, at_step;
      bit    done;
      outs_t exp_o, obs_o;
      step_t s;
      idx = 0; cyc = 0; at_step = 0; done = 1'b0;
      build_sched(op, f3, f7);
      while (!done) begin
         @(negedge clk);
         s = sched[idx];
         Op = op; Funct3 = f3; Funct7b5 = f7;
         if (stall_pct >= 0) MemReady = (at_step >= 8) || ($urandom_range(99) >= stall_pct);
         else MemReady = !(idx == stall_step && at_step < stall_n);
         Taken = (taken_sel < 0) ? 1'($urandom_range(1)) : taken_sel[0];
         reset = (cyc == rst_at);
         #1;
         exp_o = s.o;
         if (s.gate_ready && !MemReady) begin
            exp_o.pcw = 1'b0;
            exp_o.irw = 1'b0;
         end
         if (s.gate_taken && !Taken) exp_o.pcw = 1'b0;
         if (reset) begin
            exp_o.pcw = 1'b0; exp_o.irw = 1'b0; exp_o.rw = 1'b0;
            exp_o.mw = 1'b0;  exp_o.ill = 1'b0;
         end
         obs_o = {PCWrite, PCLsbClr, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal};
         check($sformatf("%s op=%b cyc%0d", name, op, cyc), 32'(obs_o), 32'(exp_o));
         cyc++;
         if (reset) begin
            done = 1'b1;
         end else if (s.hold && !MemReady) begin
            at_step++;
         end else begin
            idx++;
            at_step = 0;
            if (idx == sched.size()) done = 1'b1;
         end
         if (!done && cyc >= 40) begin
            check({name, " cycle budget"}, cyc, 0);
            done = 1'b1;
         end
      end
      if (exp_len > 0) check({name, " latency"}, cyc, exp_len);
   endtask

   logic [6:0] ops [10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111};

   initial begin
      logic [6:0] rop;
      int         rst_at;
      reset = 1'b1; Op = '0; Funct3 = '0; Funct7b5 = 1'b0; Taken = 1'b0; MemReady = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         check("reset writes", {PCWrite, IRWrite, RegWrite, MemWrite, Illegal}, 0);
      end

      run_instr(7'b0110011, 3'b000, 1'b0, -1, -1, 0, 0, -1, 4, "add");
      run_instr(7'b0000011, 3'b010, 1'b0, -1, 3, 2, 0, -1, 7, "lw_stall");
      run_instr(7'b1100011, 3'b000, 1'b0, -1, -1, 0, 0, -1, 3, "beq_nt");
      run_instr(7'b1100011, 3'b000, 1'b0, -1, -1, 0, 1, -1, 3, "beq_t");
      run_instr(7'b1100111, 3'b000, 1'b0, -1, -1, 0, 0, -1, 5, "jalr");
      run_instr(7'b1101111, 3'b000, 1'b0, -1, -1, 0, 0, -1, 4, "jal");
      run_instr(7'b1111111, 3'b000, 1'b0, -1, -1, 0, 0, -1, 2, "illegal");
      run_instr(7'b0001111, 3'b000, 1'b0, -1, -1, 0, 0, -1, 2, "fence");
      run_instr(7'b0110011, 3'b000, 1'b1, -1, -1, 0, 0, -1, 4, "sub");
      run_instr(7'b0010011, 3'b000, 1'b1, -1, -1, 0, 0, -1, 4, "addi_f7");
      run_instr(7'b0010011, 3'b101, 1'b1, -1, -1, 0, 0, -1, 4, "srai");
      run_instr(7'b0110111, 3'b000, 1'b0, -1, -1, 0, 0, -1, 4, "lui");
      run_instr(7'b0100011, 3'b010, 1'b0, -1, -1, 0, 0, -1, 4, "sw");
      run_instr(7'b0100011, 3'b010, 1'b0, -1, 3, 5, 0, 4, 0, "sw_reset");
      run_instr(7'b0010111, 3'b000, 1'b0, -1, -1, 0, 0, -1, 4, "auipc_after_rst");

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(9) == 0) rop = 7'($urandom);
         else rop = ops[$urandom_range(9)];
         rst_at = ($urandom_range(19) == 0) ? int'($urandom_range(5)) : -1;
         run_instr(rop, 3'($urandom), 1'($urandom), 30, -1, 0, -1, rst_at, 0, "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
